circular_dma_writer: RTL and testbench
======================================

# circular_dma_writer

Memory-side engine of the circular DMA write path. Consumes the buffered stream and occupancy count produced by the DMA FIFO chain, and issues AXI4 INCR write bursts into a circular buffer region in memory. Bursts never cross a 4 KB boundary or the buffer end. Exposes the write pointer, wrap count and error status to the control registers.

## Interface

- C_AXIS_WIDTH, 64, data width of the stream and of AXI WDATA; power of two, 32..1024.
- C_ADDR_WIDTH, 32, AXI address width, and width of mem_base/mem_size/write_ptr.
- C_MAX_BURST, 16, maximum beats per burst, 1..256; matches the FIFO chain's occupancy cap.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  run request from control.
- mem_base  in  C_ADDR_WIDTH  buffer base; 4 KB aligned; sampled at enable rise.
- mem_size  in  C_ADDR_WIDTH  buffer size in bytes; nonzero multiple of B = C_AXIS_WIDTH/8; sampled at enable rise.
- fifo_ready  in  1  FIFO chain active (ACTIVE or WAIT_FLUSH).
- flush_active  in  1  FIFO chain requests draining of partial data.
- occupancy  in  $clog2(C_MAX_BURST+1)  beats buffered, capped at C_MAX_BURST.
- s_axis_tdata/tlast/tvalid/tready  in/in/in/out  C_AXIS_WIDTH/1/1/1  stream from the FIFO chain; tlast is ignored.
- m_axi_awaddr/awlen/awsize/awburst/awcache/awprot/awvalid/awready  out×7/in  C_ADDR_WIDTH/8/3/2/4/3/1/1  AXI4 write address channel.
- m_axi_wdata/wstrb/wlast/wvalid/wready  out×4/in  C_AXIS_WIDTH/B/1/1/1  AXI4 write data channel.
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  AXI4 write response channel.
- busy  out  1  FSM not in ST_IDLE, or a burst is in flight.
- write_ptr  out  C_ADDR_WIDTH  byte offset of the next write, relative to mem_base.
- wrap_count  out  32  number of buffer wraps since enable rise; wraps modulo 2^32.
- axi_error  out  1  sticky; set by any BRESP != OKAY.

## Operation

- Constant outputs: awsize = log2(B), awburst = INCR (2'b01), awcache = 4'b0011, awprot = 3'b000, wstrb = all ones.
- FSM states: ST_IDLE, ST_ADDR, ST_DATA, ST_RESP.
- ST_IDLE:
  - On an enable rising edge, latch mem_base/mem_size, clear write_ptr, wrap_count and axi_error.
  - Launch a burst if enable && fifo_ready && (occupancy == C_MAX_BURST || (flush_active && occupancy != 0)).
  - On launch, latch len = min(occupancy, (mem_size − write_ptr)/B, (4096 − (addr mod 4096))/B), with addr = base + write_ptr. Then go to ST_ADDR.
- ST_ADDR:
  - awvalid = 1, awaddr = base + write_ptr, awlen = len − 1.
  - On awready, go to ST_DATA.
- ST_DATA:
  - wdata = s_axis_tdata, wvalid = s_axis_tvalid, s_axis_tready = wready. Both valid and ready are gated to 0 outside ST_DATA.
  - A beat counter counts handshakes; wlast = 1 when counter == len − 1.
  - On the last handshake, go to ST_RESP.
- ST_RESP:
  - bready = 1.
  - On bvalid: write_ptr += len·B. If the new value == mem_size, write_ptr becomes 0 and wrap_count increments.
  - If bresp != 2'b00, axi_error is set. The pointer advances regardless.
  - Return to ST_IDLE.
- enable falling mid-burst: the burst completes normally (ST_ADDR→ST_DATA→ST_RESP), then the FSM stays in ST_IDLE. No new burst starts while enable = 0.
- Only one burst is outstanding at any time. Occupancy can only fall by this block's own consumption, so a latched len is always satisfiable.
- Arithmetic is done in C_ADDR_WIDTH bits. len fits in $clog2(C_MAX_BURST+1) bits.

## Timing

- Reset values:
  - FSM = ST_IDLE.
  - awvalid, wvalid, wlast, bready, s_axis_tready, busy, axi_error = 0.
  - write_ptr, wrap_count, awaddr, awlen = 0.
  - Reset mid-burst aborts immediately; the interconnect is reset with the block.
- Latency:
  - Launch condition true in cycle N → awvalid asserted in cycle N+1.
  - AW handshake in cycle M → W beats may handshake from cycle M+1.
  - B handshake in cycle K → updated write_ptr visible in K+1; next launch evaluated in K+1, earliest awvalid in K+2.
- awaddr/awlen stay stable while awvalid = 1 and awready = 0.
- W handshakes: one beat per cycle with zero-bubble throughput when tvalid && wready hold.
- The enable rise and launch condition are never acted on in the same cycle: latch in cycle N, earliest launch in N+1.

## Test plan

All scenarios use C_AXIS_WIDTH=64, C_MAX_BURST=16, mem_base=0x1000_0000, mem_size=0x1800.

- Full burst: occupancy=16 from write_ptr=0 → awaddr=0x1000_0000, awlen=15, awsize=3; 16 W beats with wlast on beat 16; write_ptr=0x80 after B.
- Flush partial: occupancy=5, flush_active=1 → awlen=4; write_ptr advances by 0x28. With occupancy=5 and flush_active=0, no AW is issued.
- Buffer wrap: write_ptr=0x17C0, occupancy=16 → awlen=7 (8 beats to end); after B, write_ptr=0 and wrap_count=1; next burst goes to awaddr=0x1000_0000.
- 4 KB split: write_ptr=0x0FE0, occupancy=16 → awlen=3 to awaddr 0x1000_0FE0; the next burst goes to 0x1000_1000.
- Error: bresp=SLVERR on a burst → axi_error=1 and write_ptr still advances. Toggling enable low then high clears axi_error, write_ptr and wrap_count.
- Backpressure/disable: random wready/tvalid gaps with enable dropped mid-burst → exact beat count with wlast on the final beat; busy=0 one cycle after the B handshake; no further AW.

Source files
------------

// File: rtl/circular_dma_writer.sv
// Memory-side engine of the circular DMA write path: drains the FIFO chain
// into AXI4 INCR bursts that never cross a 4 KB page or the end of the ring buffer.
module circular_dma_writer #(
    parameter int C_AXIS_WIDTH = 64,
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [C_ADDR_WIDTH-1:0]       mem_base,
    input  logic [C_ADDR_WIDTH-1:0]       mem_size,
    input  logic                          fifo_ready,
    input  logic                          flush_active,
    input  logic [$clog2(C_MAX_BURST+1)-1:0] occupancy,
    input  logic [C_AXIS_WIDTH-1:0]       s_axis_tdata,
    input  logic                          s_axis_tlast,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [C_ADDR_WIDTH-1:0]       m_axi_awaddr,
    output logic [7:0]                    m_axi_awlen,
    output logic [2:0]                    m_axi_awsize,
    output logic [1:0]                    m_axi_awburst,
    output logic [3:0]                    m_axi_awcache,
    output logic [2:0]                    m_axi_awprot,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [C_AXIS_WIDTH-1:0]       m_axi_wdata,
    output logic [C_AXIS_WIDTH/8-1:0]     m_axi_wstrb,
    output logic                          m_axi_wlast,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    output logic                          busy,
    output logic [C_ADDR_WIDTH-1:0]       write_ptr,
    output logic [31:0]                   wrap_count,
    output logic                          axi_error
);

    localparam int BYTES  = C_AXIS_WIDTH / 8;
    localparam int BSHIFT = $clog2(BYTES);
    localparam int OCC_W  = $clog2(C_MAX_BURST + 1);
    localparam int AW     = C_ADDR_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [AW-1:0] PAGE_BYTES = AW'(4096);

    logic [1:0]       state_r;
    logic             enable_d_r;
    logic             rise_pend_r;
    logic [AW-1:0]    base_r;
    logic [AW-1:0]    size_r;
    logic [AW-1:0]    write_ptr_r;
    logic [31:0]      wrap_count_r;
    logic             axi_error_r;
    logic [AW-1:0]    awaddr_r;
    logic [7:0]       awlen_r;
    logic             awvalid_r;
    logic [OCC_W-1:0] len_r;
    logic [OCC_W-1:0] beat_r;

    logic             rise_s;
    logic             launch_s;
    logic [AW-1:0]    addr_s;
    logic [AW-1:0]    occ_ext_s;
    logic [AW-1:0]    room_buf_s;
    logic [AW-1:0]    room_4k_s;
    logic [AW-1:0]    first_s;
    logic [AW-1:0]    len_ext_s;
    logic [OCC_W-1:0] len_s;
    logic             w_hs_s;
    logic             last_beat_s;
    logic [AW-1:0]    next_ptr_s;
    logic             unused_s;

    assign rise_s   = enable & ~enable_d_r;
    assign launch_s = enable & fifo_ready &
                      ((occupancy == OCC_W'(C_MAX_BURST)) |
                       (flush_active & (occupancy != {OCC_W{1'b0}})));

    // Burst length: smallest of data on hand, room to buffer end, room to next 4 KB page.
    assign addr_s     = base_r + write_ptr_r;
    assign occ_ext_s  = {{(AW-OCC_W){1'b0}}, occupancy};
    assign room_buf_s = (size_r - write_ptr_r) >> BSHIFT;
    assign room_4k_s  = (PAGE_BYTES - {{(AW-12){1'b0}}, addr_s[11:0]}) >> BSHIFT;
    assign first_s    = (room_buf_s < occ_ext_s) ? room_buf_s : occ_ext_s;
    assign len_ext_s  = (room_4k_s < first_s) ? room_4k_s : first_s;
    assign len_s      = len_ext_s[OCC_W-1:0];

    assign w_hs_s      = (state_r == ST_DATA) & s_axis_tvalid & m_axi_wready;
    assign last_beat_s = (beat_r == (len_r - OCC_W'(1)));
    assign next_ptr_s  = write_ptr_r + ({{(AW-OCC_W){1'b0}}, len_r} << BSHIFT);
    assign unused_s    = ^{s_axis_tlast, len_ext_s[AW-1:OCC_W]};

    // Burst sequencing, pointer/wrap bookkeeping and sticky error capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            enable_d_r   <= 1'b0;
            rise_pend_r  <= 1'b0;
            base_r       <= {AW{1'b0}};
            size_r       <= {AW{1'b0}};
            write_ptr_r  <= {AW{1'b0}};
            wrap_count_r <= 32'd0;
            axi_error_r  <= 1'b0;
            awaddr_r     <= {AW{1'b0}};
            awlen_r      <= 8'd0;
            awvalid_r    <= 1'b0;
            len_r        <= {OCC_W{1'b0}};
            beat_r       <= {OCC_W{1'b0}};
        end else begin
            enable_d_r <= enable;
            // A rise seen mid-burst is remembered and honoured once back in idle.
            if (rise_s && (state_r != ST_IDLE)) begin
                rise_pend_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (rise_s || rise_pend_r) begin
                        rise_pend_r  <= 1'b0;
                        base_r       <= mem_base;
                        size_r       <= mem_size;
                        write_ptr_r  <= {AW{1'b0}};
                        wrap_count_r <= 32'd0;
                        axi_error_r  <= 1'b0;
                    end else if (launch_s) begin
                        len_r     <= len_s;
                        awaddr_r  <= addr_s;
                        awlen_r   <= 8'(len_s - OCC_W'(1));
                        awvalid_r <= 1'b1;
                        state_r   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (m_axi_awready) begin
                        awvalid_r <= 1'b0;
                        beat_r    <= {OCC_W{1'b0}};
                        state_r   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_hs_s) begin
                        beat_r <= beat_r + OCC_W'(1);
                        if (last_beat_s) begin
                            state_r <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (m_axi_bvalid) begin
                        if (next_ptr_s == size_r) begin
                            write_ptr_r  <= {AW{1'b0}};
                            wrap_count_r <= wrap_count_r + 32'd1;
                        end else begin
                            write_ptr_r <= next_ptr_s;
                        end
                        if (m_axi_bresp != 2'b00) begin
                            axi_error_r <= 1'b1;
                        end
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign m_axi_awaddr  = awaddr_r;
    assign m_axi_awlen   = awlen_r;
    assign m_axi_awsize  = 3'(BSHIFT);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_r;

    assign m_axi_wdata   = s_axis_tdata;
    assign m_axi_wstrb   = {BYTES{1'b1}};
    assign m_axi_wvalid  = (state_r == ST_DATA) & s_axis_tvalid;
    assign m_axi_wlast   = (state_r == ST_DATA) & last_beat_s;
    assign s_axis_tready = (state_r == ST_DATA) & m_axi_wready;

    assign m_axi_bready  = (state_r == ST_RESP);
    assign busy          = (state_r != ST_IDLE);
    assign write_ptr     = write_ptr_r;
    assign wrap_count    = wrap_count_r;
    assign axi_error     = axi_error_r;

endmodule

// File: tb/tb_circular_dma_writer.sv
// Directed bench for circular_dma_writer: a FIFO/AXI-slave emulator plus a
// transaction-level model of the ring buffer checked against the DUT every cycle.
module tb_circular_dma_writer;

    localparam int W  = 64;
    localparam int A  = 32;
    localparam int MB = 16;
    localparam int OW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [A-1:0]  mem_base;
    logic [A-1:0]  mem_size;
    logic          fifo_ready;
    logic          flush_active;
    logic [OW-1:0] occupancy;
    logic [W-1:0]  s_axis_tdata;
    logic          s_axis_tlast;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [A-1:0]  m_axi_awaddr;
    logic [7:0]    m_axi_awlen;
    logic [2:0]    m_axi_awsize;
    logic [1:0]    m_axi_awburst;
    logic [3:0]    m_axi_awcache;
    logic [2:0]    m_axi_awprot;
    logic          m_axi_awvalid;
    logic          m_axi_awready;
    logic [W-1:0]  m_axi_wdata;
    logic [7:0]    m_axi_wstrb;
    logic          m_axi_wlast;
    logic          m_axi_wvalid;
    logic          m_axi_wready;
    logic [1:0]    m_axi_bresp;
    logic          m_axi_bvalid;
    logic          m_axi_bready;
    logic          busy;
    logic [A-1:0]  write_ptr;
    logic [31:0]   wrap_count;
    logic          axi_error;

    always #5 clk = ~clk;

    circular_dma_writer #(.C_AXIS_WIDTH(W), .C_ADDR_WIDTH(A), .C_MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mem_base(mem_base), .mem_size(mem_size),
        .fifo_ready(fifo_ready), .flush_active(flush_active), .occupancy(occupancy),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .busy(busy), .write_ptr(write_ptr), .wrap_count(wrap_count), .axi_error(axi_error)
    );

    int total = 0;
    int bad   = 0;

    // Model of the ring buffer and burst in progress (0 idle, 1 address, 2 data, 3 response).
    int          m_phase = 0;
    logic [31:0] m_base = 32'd0, m_size = 32'd0, m_ptr = 32'd0, m_wrap = 32'd0;
    logic        m_err = 1'b0, m_prev_en = 1'b0, m_pend = 1'b0;
    int          m_len = 0, m_beat = 0;
    logic [31:0] m_total = 32'd0;

    // Environment state.
    int          level = 0;
    bit          gaps = 1'b0, err_inj = 1'b0, b_pending = 1'b0, b_clear = 1'b0, mon_on = 1'b0;
    int          aw_count = 0;
    logic [31:0] last_awaddr = 32'd0;
    logic [7:0]  last_awlen = 8'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int umin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Per-cycle: drive FIFO/slave at negedge, then compare and advance the model.
    initial begin
        forever begin
            @(negedge clk);
            if (b_clear) begin
                m_axi_bvalid = 1'b0;
                b_clear = 1'b0;
            end else if (b_pending && !m_axi_bvalid && (!gaps || $urandom_range(0, 2) == 0)) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = err_inj ? 2'b10 : 2'b00;
            end
            occupancy     = (level > MB) ? OW'(MB) : OW'(level);
            s_axis_tvalid = (level > 0) && (!gaps || $urandom_range(0, 3) != 0);
            s_axis_tdata  = {32'hC0DE_0000, m_total};
            m_axi_wready  = !gaps || $urandom_range(0, 3) != 0;
            m_axi_awready = !gaps || $urandom_range(0, 2) != 0;
            #1;
            if (!rst_n) begin
                m_phase = 0; m_ptr = 32'd0; m_wrap = 32'd0; m_err = 1'b0;
                m_prev_en = 1'b0; m_pend = 1'b0;
            end else if (mon_on) begin
                check("awvalid", m_axi_awvalid, m_phase == 1);
                check("bready", m_axi_bready, m_phase == 3);
                check("busy", busy, m_phase != 0);
                check("wvalid", m_axi_wvalid, (m_phase == 2) && s_axis_tvalid);
                check("tready", s_axis_tready, (m_phase == 2) && m_axi_wready);
                check("wlast", m_axi_wlast, (m_phase == 2) && (m_beat == m_len - 1));
                check("write_ptr", write_ptr, m_ptr);
                check("wrap_count", wrap_count, m_wrap);
                check("axi_error", axi_error, m_err);
                if (m_phase == 1) begin
                    check("awaddr", m_axi_awaddr, m_base + m_ptr);
                    check("awlen", m_axi_awlen, 64'(m_len - 1));
                end
                begin
                    bit rise;
                    int occ;
                    rise = enable && !m_prev_en;
                    m_prev_en = enable;
                    occ = umin(level, MB);
                    if (rise && m_phase != 0) m_pend = 1'b1;
                    case (m_phase)
                        0: begin
                            if (rise || m_pend) begin
                                m_pend = 1'b0; m_base = mem_base; m_size = mem_size;
                                m_ptr = 32'd0; m_wrap = 32'd0; m_err = 1'b0;
                            end else if (enable && fifo_ready &&
                                         (occ == MB || (flush_active && occ != 0))) begin
                                m_len = umin(occ, int'((m_size - m_ptr) / 8));
                                m_len = umin(m_len, int'((4096 - ((m_base + m_ptr) % 4096)) / 8));
                                m_phase = 1;
                            end
                        end
                        1: begin
                            if (m_axi_awready) begin
                                aw_count++;
                                last_awaddr = m_axi_awaddr;
                                last_awlen  = m_axi_awlen;
                                m_beat  = 0;
                                m_phase = 2;
                            end
                        end
                        2: begin
                            if (s_axis_tvalid && m_axi_wready) begin
                                check("wdata", m_axi_wdata, {32'hC0DE_0000, m_total});
                                level--;
                                m_total++;
                                m_beat++;
                                if (m_beat == m_len) begin
                                    m_phase = 3;
                                    b_pending = 1'b1;
                                end
                            end
                        end
                        default: begin
                            if (m_axi_bvalid) begin
                                m_ptr = m_ptr + 32'(m_len * 8);
                                if (m_ptr == m_size) begin
                                    m_ptr = 32'd0;
                                    m_wrap++;
                                end
                                if (m_axi_bresp != 2'b00) m_err = 1'b1;
                                m_phase = 0;
                                b_pending = 1'b0;
                                b_clear = 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Wait until the model is idle and no launch condition holds for a few cycles.
    task automatic wait_quiet();
        int q = 0;
        for (int i = 0; i < 3000 && q < 4; i++) begin
            cycles(1);
            if (m_phase == 0 && !(enable && fifo_ready && (level >= MB || (flush_active && level > 0))))
                q++;
            else
                q = 0;
        end
        check("quiet_timeout", q >= 4, 1'b1);
    endtask

    task automatic feed(input int beats);
        level = level + beats;
        wait_quiet();
        flush_active = 1'b1;
        wait_quiet();
        flush_active = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; enable = 1'b0; mem_base = 32'h1000_0000; mem_size = 32'h0000_1800;
        fifo_ready = 1'b1; flush_active = 1'b0; s_axis_tlast = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        cycles(3);
        check("rst_busy", busy, 1'b0);
        check("rst_awvalid", m_axi_awvalid, 1'b0);
        check("rst_wlast", m_axi_wlast, 1'b0);
        check("rst_bready", m_axi_bready, 1'b0);
        check("rst_ptr", write_ptr, 32'd0);
        check("rst_awaddr", m_axi_awaddr, 32'd0);
        check("rst_awlen", m_axi_awlen, 8'd0);
        check("rst_err", axi_error, 1'b0);
        rst_n = 1'b1;
        mon_on = 1'b1;

        // Full burst from the buffer start, with enable rise and data arriving together.
        enable = 1'b1; level = 16;
        wait_quiet();
        check("full_awcnt", aw_count, 1);
        check("full_awaddr", last_awaddr, 32'h1000_0000);
        check("full_awlen", last_awlen, 8'd15);
        check("awsize", m_axi_awsize, 3'd3);
        check("awburst", m_axi_awburst, 2'b01);
        check("awcache", m_axi_awcache, 4'b0011);
        check("awprot", m_axi_awprot, 3'b000);
        check("wstrb", m_axi_wstrb, 8'hFF);
        check("full_ptr", write_ptr, 32'h80);

        // Partial data waits for flush.
        level = 5;
        cycles(20);
        check("noflush_awcnt", aw_count, 1);
        flush_active = 1'b1;
        wait_quiet();
        flush_active = 1'b0;
        check("flush_awlen", last_awlen, 8'd4);
        check("flush_ptr", write_ptr, 32'hA8);

        // Restart, then walk to 0xFE0 and split at the 4 KB page.
        enable = 1'b0; cycles(2); enable = 1'b1; cycles(2);
        check("restart_ptr", write_ptr, 32'd0);
        feed(508);
        check("pre4k_ptr", write_ptr, 32'hFE0);
        level = 16;
        wait_quiet();
        check("split_awaddr", last_awaddr, 32'h1000_0FE0);
        check("split_awlen", last_awlen, 8'd3);
        check("split_ptr", write_ptr, 32'h1000);
        level = level + 4;
        wait_quiet();
        check("page_awaddr", last_awaddr, 32'h1000_1000);
        check("page_awlen", last_awlen, 8'd15);

        // Walk to 0x17C0 and wrap.
        feed(232);
        check("prewrap_ptr", write_ptr, 32'h17C0);
        level = 16;
        wait_quiet();
        check("wrap_awlen", last_awlen, 8'd7);
        check("wrap_ptr", write_ptr, 32'd0);
        check("wrap_cnt", wrap_count, 32'd1);
        level = level + 8;
        wait_quiet();
        check("postwrap_awaddr", last_awaddr, 32'h1000_0000);
        check("postwrap_ptr", write_ptr, 32'h80);

        // SLVERR: sticky error, pointer still advances, cleared by re-enable.
        err_inj = 1'b1; level = 16;
        wait_quiet();
        err_inj = 1'b0;
        check("err_flag", axi_error, 1'b1);
        check("err_ptr", write_ptr, 32'h100);
        enable = 1'b0; cycles(2);
        check("err_sticky", axi_error, 1'b1);
        enable = 1'b1; cycles(2);
        check("clr_err", axi_error, 1'b0);
        check("clr_ptr", write_ptr, 32'd0);
        check("clr_wrap", wrap_count, 32'd0);

        // Backpressure with enable dropped mid-burst.
        gaps = 1'b1; n = aw_count; level = 16;
        for (int i = 0; i < 200 && aw_count == n; i++) cycles(1);
        check("bp_aw_seen", aw_count, n + 1);
        cycles(2);
        enable = 1'b0;
        wait_quiet();
        check("bp_busy", busy, 1'b0);
        check("bp_ptr", write_ptr, 32'h80);
        check("bp_awlen", last_awlen, 8'd15);
        n = aw_count;
        level = level + 32;
        cycles(40);
        check("bp_no_aw", aw_count, n);
        gaps = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
